// File: rtl/rr_grant_sched_pkg.sv
// -----------------------------------------------------------------------------
// rr_sched_pkg
// Shared constants, state encoding and helper function for the round-robin
// grant scheduler (rr_grant_sched) and its sub-blocks.
//   N          : number of requesters (fixed at 32 for this revision)
//   IW         : requester index width, log2(N)
//   sched_state_e : scheduler FSM state encoding
//   onehot2idx : converts a one-hot (or all-zero) vector to its binary index
// -----------------------------------------------------------------------------
package rr_sched_pkg;

    localparam int N  = 32;
    localparam int IW = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } sched_state_e;

    // OR-reduction of set-bit indices; exact for one-hot input, 0 for all-zero.
    function automatic logic [IW-1:0] onehot2idx(input logic [N-1:0] oh);
        logic [IW-1:0] idx;
        idx = {IW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = idx | IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_sched_if.sv
// -----------------------------------------------------------------------------
// rr_grant_sched_if
// Bundle of the requester/resource handshake signals around the scheduler.
//   req     : level request per requester
//   last    : final beat of the granted transaction
//   beat    : granted requester transfers one beat this cycle
//   res_rdy : shared resource can accept a beat or a new grant
//   gnt     : registered one-hot grant (or zero)
//   gnt_idx : binary index of gnt (0 when gnt is zero)
//   gnt_vld : gnt is non-zero
//   tmo_err : one-cycle pulse on a watchdog release
// Modports: master = requester/resource side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface rr_grant_sched_if;
    import rr_sched_pkg::*;

    logic [N-1:0]  req;
    logic          last;
    logic          beat;
    logic          res_rdy;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_vld;
    logic          tmo_err;

    modport master (
        output req, last, beat, res_rdy,
        input  gnt, gnt_idx, gnt_vld, tmo_err
    );

    modport slave (
        input  req, last, beat, res_rdy,
        output gnt, gnt_idx, gnt_vld, tmo_err
    );

endinterface

// File: rtl/rr_grant_sched_fpri.sv
// -----------------------------------------------------------------------------
// fpri_onehot32
// Combinational 32-bit fixed-priority one-hot encoder: the lowest-index set
// bit of req_i wins. Output is all-zero when req_i is all-zero.
//   req_i : request vector
//   gnt_o : one-hot winner (or zero)
// -----------------------------------------------------------------------------
module fpri_onehot32 (
    input  logic [31:0] req_i,
    output logic [31:0] gnt_o
);

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        gnt_o = req_i & (~req_i + 32'd1);
    end

endmodule

// File: rtl/rr_grant_sched.sv
// -----------------------------------------------------------------------------
// rr_grant_sched
// Round-robin grant scheduler sharing one resource among 32 requesters.
// A rotating mask (bits strictly above the last granted index) is applied in
// front of a fixed-priority encoder; if the masked path finds nothing the
// unmasked path is used. A grant is held for a multi-beat transaction and
// released on a valid last beat or by the idle watchdog, with zero-bubble
// handoff to the next winner.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : rr_grant_sched_if.slave (req/last/beat/res_rdy in, gnt/... out)
//   TMO : idle grant cycles before a forced release (1..65535)
// -----------------------------------------------------------------------------
module rr_grant_sched
    import rr_sched_pkg::*;
#(
    parameter int unsigned TMO = 255
) (
    input  logic              clk,
    input  logic              rst,
    rr_grant_sched_if.slave   bus
);

    localparam logic [15:0] TMO_V = 16'(TMO);

    sched_state_e  state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic          gnt_vld_q, gnt_vld_d;
    logic          tmo_err_q, tmo_err_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [15:0]   wd_q, wd_d;

    logic [IW-1:0] arb_ptr_s;
    logic [N-1:0]  arb_mask_s;
    logic [N-1:0]  req_masked_s;
    logic [N-1:0]  win_masked_s;
    logic [N-1:0]  win_unmasked_s;
    logic [N-1:0]  win_s;
    logic          valid_beat_s;
    logic          last_beat_s;
    logic          wd_expired_s;

    // Mask base: in BUSY the current grant becomes the pointer on release,
    // so arbitrate against it directly to allow same-cycle handoff.
    always_comb begin
        if (state_q == ST_BUSY) begin
            arb_ptr_s = gnt_idx_q;
        end else begin
            arb_ptr_s = ptr_q;
        end
        // Bits strictly above arb_ptr_s; ptr = 31 shifts out to an empty mask.
        arb_mask_s   = ~((32'd2 << arb_ptr_s) - 32'd1);
        req_masked_s = bus.req & arb_mask_s;
    end

    fpri_onehot32 u_fpri_masked (
        .req_i (req_masked_s),
        .gnt_o (win_masked_s)
    );

    fpri_onehot32 u_fpri_unmasked (
        .req_i (bus.req),
        .gnt_o (win_unmasked_s)
    );

    // Winner selection and beat/watchdog qualifiers.
    always_comb begin
        if (win_masked_s != {N{1'b0}}) begin
            win_s = win_masked_s;
        end else begin
            win_s = win_unmasked_s;
        end
        valid_beat_s = bus.beat & bus.res_rdy;
        last_beat_s  = valid_beat_s & bus.last;
        wd_expired_s = (wd_q == TMO_V);
    end

    // Next-state logic for the grant FSM, pointer and watchdog.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        wd_d      = wd_q;
        tmo_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((bus.req != {N{1'b0}}) && bus.res_rdy) begin
                    state_d   = ST_BUSY;
                    gnt_d     = win_s;
                    gnt_idx_d = onehot2idx(win_s);
                    wd_d      = 16'd0;
                end else begin
                    gnt_d     = {N{1'b0}};
                    gnt_idx_d = {IW{1'b0}};
                end
            end
            ST_BUSY: begin
                if (last_beat_s || wd_expired_s) begin
                    ptr_d     = gnt_idx_q;
                    // A valid last beat wins over a coincident timeout.
                    tmo_err_d = ~last_beat_s;
                    wd_d      = 16'd0;
                    if ((win_s != {N{1'b0}}) && bus.res_rdy) begin
                        state_d   = ST_BUSY;
                        gnt_d     = win_s;
                        gnt_idx_d = onehot2idx(win_s);
                    end else begin
                        state_d   = ST_IDLE;
                        gnt_d     = {N{1'b0}};
                        gnt_idx_d = {IW{1'b0}};
                    end
                end else if (valid_beat_s) begin
                    wd_d = 16'd0;
                end else if (!wd_expired_s) begin
                    wd_d = wd_q + 16'd1;
                end else begin
                    wd_d = wd_q;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gnt_d     = {N{1'b0}};
                gnt_idx_d = {IW{1'b0}};
                wd_d      = 16'd0;
            end
        endcase
        gnt_vld_d = (gnt_d != {N{1'b0}});
    end

    // State and output registers; reset drops any grant without a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= {N{1'b0}};
            gnt_idx_q <= {IW{1'b0}};
            gnt_vld_q <= 1'b0;
            tmo_err_q <= 1'b0;
            ptr_q     <= IW'(N - 1);
            wd_q      <= 16'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            tmo_err_q <= tmo_err_d;
            ptr_q     <= ptr_d;
            wd_q      <= wd_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.tmo_err = tmo_err_q;

endmodule

// File: doc/rr_grant_sched.md
# rr_grant_sched

Round-robin grant scheduler that shares one downstream resource among 32 requesters. It wraps the team's 32-bit fixed-priority one-hot encoder: that encoder picks the lowest-index active input; this block adds a rotating priority mask, a registered one-hot grant held for a multi-beat transaction, a handshake with the resource, and a watchdog that reclaims stuck grants. It sits between the requester array and the shared datapath resource.

## Interface

- `N`, default 32: number of requesters. Fixed at 32 for this revision.
- `IW`, default 5: index width, log2(N).
- `TMO`, default 255: maximum number of idle grant cycles before a forced release. Range 1..65535.
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req`, in, N: level request per requester. Bit i is requester i.
- `last`, in, 1: the granted requester's final beat. Sampled only on a beat.
- `beat`, in, 1: the granted requester transfers one beat this cycle.
- `res_rdy`, in, 1: the resource can accept a beat or a new grant.
- `gnt`, out, N: registered one-hot grant, or all-zero.
- `gnt_idx`, out, IW: binary index of `gnt`. Value is 0 when `gnt` = 0.
- `gnt_vld`, out, 1: asserted exactly when `gnt` ≠ 0.
- `tmo_err`, out, 1: one-cycle pulse on a watchdog release.

## Operation

- States:
  - IDLE: `gnt` = 0.
  - BUSY: `gnt` is one-hot and held.
- Pointer `ptr` (IW bits) holds the index of the last granted requester.
- Mask `m` = bits strictly above `ptr`. Arbitration works as follows:
  - Compute `w = enc(req & m)`.
  - If that result is zero, use `w = enc(req)` instead.
  - `enc` is the fixed-priority one-hot encoder (lowest index wins).
- IDLE → BUSY: when `req` ≠ 0 and `res_rdy` = 1.
  - `gnt <= w`.
  - `gnt_idx <= index(w)`.
  - Watchdog counter `wd <= 0`.
- BUSY behaviour:
  - A beat is valid only when `beat & res_rdy`.
  - Each valid beat clears `wd`.
  - Each cycle without a valid beat increments `wd`, saturating at `TMO`.
- Release condition: a valid beat with `last` = 1, or `wd` = `TMO`. On release:
  - `ptr <= gnt_idx`.
  - Re-arbitrate in the same cycle, using a mask computed from the current `gnt_idx`.
  - If the re-arbitration result is nonzero and `res_rdy` = 1, stay in BUSY with the new grant (zero-bubble handoff).
  - Otherwise go to IDLE.
- The releasing requester's `req` may still be high. The rotation gives it lowest priority, so it wins only if it is the sole requester.
- Deassertion of `req[gnt_idx]` during BUSY does not revoke the grant. Only `last`, the watchdog, or `rst` release it.
- Watchdog release: pulses `tmo_err` for one cycle. A simultaneous valid `last` beat takes precedence, so `tmo_err` stays 0.
- `beat` and `last` received in IDLE are ignored.

## Timing

- Reset values:
  - `gnt` = 0, `gnt_idx` = 0, `gnt_vld` = 0, `tmo_err` = 0.
  - `ptr` = N-1, so the first arbitration favours index 0.
  - `wd` = 0, state = IDLE.
- Reset mid-transaction drops the grant on the next edge. No release side effects occur.
- Latency:
  - `req` sampled in IDLE → `gnt` valid on the next cycle (1 cycle).
  - Release cycle → new `gnt` on the next cycle (no idle gap).
- `res_rdy` = 0 in IDLE blocks grant issue. `res_rdy` = 0 in BUSY stalls beats and counts toward the watchdog.
- Mask wrap-around: when `ptr` = 31, `m` = 0, so the unmasked path is always used.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Structure

- Shared package `rr_sched_pkg`:
  - `N` and `IW` constants.
  - State enum {IDLE, BUSY}.
  - `onehot2idx` function.
- Sub-module `fpri_onehot32`: combinational lowest-index-wins one-hot encoder. It is instantiated twice (masked and unmasked paths).
- Pointer register, mask generation, FSM, and watchdog live in the top-level block. Target size is about 200 lines.

## Test plan

- Reset, then `req` = 0x0000_0001 with `res_rdy` = 1 → next cycle `gnt` = 0x1, `gnt_idx` = 0. Then one beat with `last` = 1 → `gnt` = 0 the following cycle.
- `req` = 0xFFFF_FFFF held, every grant completes with a single `last` beat → `gnt_idx` sequence is 0, 1, 2, …, 31, 0 with no idle cycles. This covers wrap-around at 31.
- `ptr` = 5, `req` = 0x0000_0021 (bits 0 and 5) → grant goes to 0, then to 5.
- Grant held with `beat` = 0 for 255 cycles → release at `wd` = 255, `tmo_err` pulses for one cycle, and the next requester is granted.
- `res_rdy` = 0 with `req` = 0x10 → no grant. `res_rdy` rising → `gnt` = 0x10 one cycle later.
- `rst` asserted mid-transaction with `gnt` = 0x8 → next cycle all outputs are 0. The next arbitration with `req` = 0x9 grants index 0.
